// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit sampling, parity/framing checks, sticky rdy.
// Optional overrun flag and ovr_err port are built when UART_RX_OVR_EN is defined.
`timescale 1ns/1ps
module uart_rx_param #(
   parameter int BAUD_DIV  = 5208,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 RX,
   input  logic                 clr_rdy,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rdy,
   output logic                 frm_err,
   output logic                 par_err
`ifdef UART_RX_OVR_EN
   ,
   output logic                 ovr_err
`endif
);

   localparam int CW = $clog2(BAUD_DIV);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_V   = CW'(BAUD_DIV >> 1);
   localparam logic [CW-1:0] RELOAD_V = CW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic          ODD_PAR  = (PARITY == 2);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t               state, state_nx;
   logic                 rx_meta, rxs;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_mis;
   logic                 seen_high;
   logic                 sample;
   logic                 start_det, start_ok, shift_en, par_en, done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= RX;
         rxs     <= rx_meta;
      end
   end

   assign sample = (cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (seen_high && !rxs) state_nx = START;
         START: if (sample) state_nx = rxs ? IDLE : DATA;
         DATA:  if (sample && bit_cnt == LAST_BIT) state_nx = (PARITY != 0) ? PAR : STOP;
         PAR:   if (sample) state_nx = STOP;
         STOP:  if (sample) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      start_det = (state == IDLE) && seen_high && !rxs;
      start_ok  = (state == START) && sample && !rxs;
      shift_en  = (state == DATA) && sample;
      par_en    = (state == PAR) && sample;
      done      = (state == STOP) && sample;
   end

   // First wait is half a bit so every later sample lands mid-bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               cnt <= '0;
      else if (start_det)       cnt <= HALF_V;
      else if (state == IDLE)   cnt <= '0;
      else if (sample)          cnt <= RELOAD_V;
      else                      cnt <= cnt - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         shreg   <= '0;
         par_mis <= 1'b0;
      end else begin
         if (start_ok)      bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + BW'(1);
         if (shift_en) shreg <= {rxs, shreg[DATA_BITS-1:1]};
         if (par_en)   par_mis <= ((^shreg) ^ rxs) != ODD_PAR;
      end
   end

   // A low stop bit (break) forces the line to be seen high again before the next start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    seen_high <= 1'b1;
      else if (done) seen_high <= rxs;
      else if (rxs)  seen_high <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data <= '0;
         rdy     <= 1'b0;
         frm_err <= 1'b0;
         par_err <= 1'b0;
      end else if (done) begin
         rx_data <= shreg;
         rdy     <= 1'b1;
         frm_err <= ~rxs;
         par_err <= (PARITY != 0) ? par_mis : 1'b0;
      end else if (clr_rdy) begin
         rdy     <= 1'b0;
         frm_err <= 1'b0;
         par_err <= 1'b0;
      end
   end

`ifdef UART_RX_OVR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              ovr_err <= 1'b0;
      else if (done && rdy)    ovr_err <= 1'b1;
      else if (clr_rdy)        ovr_err <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (no/even/odd parity) at BAUD_DIV=16, DATA_BITS=8.
// Define UART_RX_OVR_EN to also exercise the overrun flag.
`timescale 1ns/1ps
module tb_uart_rx_param;

   localparam int B    = 16;
   localparam int D    = 8;
   localparam int HALF = B / 2;

   typedef struct {
      int         sel;
      logic [7:0] data;
      bit         pbit;
      bit         stop;
      logic [7:0] exp_data;
      bit         exp_frm;
      bit         exp_par;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic rx_line;
   logic clr_rdy;
   int   sel;
   logic rx0, rx1, rx2;
   logic [7:0] data0, data1, data2;
   logic rdy0, rdy1, rdy2, frm0, frm1, frm2, par0, par1, par2;
`ifdef UART_RX_OVR_EN
   logic ovr0, ovr1, ovr2;
`endif
   logic [7:0] data_mux;
   logic rdy_mux, frm_mux, par_mux;

   int cyc = 0;
   int last_rise = -1;
   int start_cyc = 0;
   logic rdy_prev = 1'b0;
   int checks = 0;
   int passed = 0;
   vec_t vecs[9];

   assign rx0 = (sel == 0) ? rx_line : 1'b1;
   assign rx1 = (sel == 1) ? rx_line : 1'b1;
   assign rx2 = (sel == 2) ? rx_line : 1'b1;

   uart_rx_param #(.BAUD_DIV(B), .DATA_BITS(D), .PARITY(0)) u0 (
      .clk(clk), .rst_n(rst_n), .RX(rx0), .clr_rdy(clr_rdy),
      .rx_data(data0), .rdy(rdy0), .frm_err(frm0), .par_err(par0)
`ifdef UART_RX_OVR_EN
      , .ovr_err(ovr0)
`endif
   );
   uart_rx_param #(.BAUD_DIV(B), .DATA_BITS(D), .PARITY(1)) u1 (
      .clk(clk), .rst_n(rst_n), .RX(rx1), .clr_rdy(clr_rdy),
      .rx_data(data1), .rdy(rdy1), .frm_err(frm1), .par_err(par1)
`ifdef UART_RX_OVR_EN
      , .ovr_err(ovr1)
`endif
   );
   uart_rx_param #(.BAUD_DIV(B), .DATA_BITS(D), .PARITY(2)) u2 (
      .clk(clk), .rst_n(rst_n), .RX(rx2), .clr_rdy(clr_rdy),
      .rx_data(data2), .rdy(rdy2), .frm_err(frm2), .par_err(par2)
`ifdef UART_RX_OVR_EN
      , .ovr_err(ovr2)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      case (sel)
         1:       begin data_mux = data1; rdy_mux = rdy1; frm_mux = frm1; par_mux = par1; end
         2:       begin data_mux = data2; rdy_mux = rdy2; frm_mux = frm2; par_mux = par2; end
         default: begin data_mux = data0; rdy_mux = rdy0; frm_mux = frm0; par_mux = par0; end
      endcase
   end

   // Records the cycle on which the selected receiver's rdy last rose.
   always @(negedge clk) begin
      if (rdy_mux && !rdy_prev) last_rise = cyc;
      rdy_prev = rdy_mux;
   end

   // Reference: parity error when the count of ones (data + parity bit) has the wrong sense.
   function automatic bit model_par_err(input int mode, input logic [7:0] d, input bit pb);
      int ones;
      ones = $countones(d) + int'(pb);
      if (mode == 0) return 1'b0;
      if (mode == 1) return (ones % 2) == 1;
      return (ones % 2) == 0;
   endfunction

   function automatic int model_latency(input int mode);
      return HALF + (1 + D + ((mode != 0) ? 1 : 0)) * B + 3;
   endfunction

   task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   task automatic checkRange(input string nm, input int act, input int lo, input int hi);
      checks++;
      if (act >= lo && act <= hi) passed++;
      else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
   endtask

   task automatic clearFlags();
      @(posedge clk); #1 clr_rdy = 1'b1;
      @(posedge clk); #1 clr_rdy = 1'b0;
   endtask

   task automatic applyStimulus(input logic [7:0] d, input bit pb, input bit use_par, input bit stop);
      @(posedge clk); #1;
      rx_line   = 1'b0;
      start_cyc = cyc;
      repeat (B) @(posedge clk);
      #1;
      for (int i = 0; i < D; i++) begin
         rx_line = d[i];
         repeat (B) @(posedge clk);
         #1;
      end
      if (use_par) begin
         rx_line = pb;
         repeat (B) @(posedge clk);
         #1;
      end
      rx_line = stop;
      repeat (B) @(posedge clk);
      #1 rx_line = 1'b1;
   endtask

   task automatic checkFrame(input logic [7:0] exp_d, input bit exp_f, input bit exp_p);
      checkOutput("rdy", rdy_mux, 1);
      checkOutput("rx_data", data_mux, exp_d);
      checkOutput("frm_err", frm_mux, exp_f);
      checkOutput("par_err", par_mux, exp_p);
   endtask

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] d;
      bit pb, st;
      int s, lat, lw;

      vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
      vecs[1] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
      vecs[2] = '{0, 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0};
      vecs[3] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1};
      vecs[4] = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0};
      vecs[5] = '{2, 8'h03, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0};
      vecs[6] = '{2, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b1};
      vecs[7] = '{1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
      vecs[8] = '{2, 8'hFF, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b1};

      rst_n   = 1'b0;
      rx_line = 1'b1;
      clr_rdy = 1'b0;
      sel     = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_rdy", rdy0, 0);
      checkOutput("reset_data", data0, 0);
      checkOutput("reset_frm", frm0, 0);
      checkOutput("reset_par", par1, 0);
`ifdef UART_RX_OVR_EN
      checkOutput("reset_ovr", ovr0, 0);
`endif
      rst_n = 1'b1;
      repeat (4) @(posedge clk);

      for (int i = 0; i < 9; i++) begin
         sel = vecs[i].sel;
         clearFlags();
         checkOutput("clr_rdy", rdy_mux, 0);
         applyStimulus(vecs[i].data, vecs[i].pbit, vecs[i].sel != 0, vecs[i].stop);
         checkFrame(vecs[i].exp_data, vecs[i].exp_frm, vecs[i].exp_par);
         lat = last_rise - start_cyc;
         lw  = model_latency(vecs[i].sel);
         checkRange("latency", lat, lw - 1, lw + 1);
         repeat (B) @(posedge clk);
      end

      // Short glitch must be rejected as a false start.
      sel = 0;
      clearFlags();
      @(posedge clk); #1 rx_line = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx_line = 1'b1;
      repeat (3 * B) @(posedge clk);
      #1 checkOutput("glitch_rdy", rdy0, 0);
      applyStimulus(8'h55, 1'b0, 1'b0, 1'b1);
      checkFrame(8'h55, 1'b0, 1'b0);

      // Break: one all-zero frame with framing error, then no retrigger while low.
      clearFlags();
      @(posedge clk); #1 rx_line = 1'b0;
      repeat (12 * B) @(posedge clk);
      #1;
      checkFrame(8'h00, 1'b1, 1'b0);
      clearFlags();
      repeat (4 * B) @(posedge clk);
      #1 checkOutput("break_no_retrigger", rdy0, 0);
      rx_line = 1'b1;
      repeat (2 * B) @(posedge clk);
      applyStimulus(8'h5A, 1'b0, 1'b0, 1'b1);
      checkFrame(8'h5A, 1'b0, 1'b0);

      // Reset mid-frame clears everything at once.
      @(posedge clk); #1 rx_line = 1'b0;
      repeat (HALF + 4 + 3 * B) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checkOutput("midreset_rdy", rdy0, 0);
      checkOutput("midreset_data", data0, 0);
      checkOutput("midreset_frm", frm0, 0);
      checkOutput("midreset_par", par0, 0);
      rx_line = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      applyStimulus(8'h7E, 1'b0, 1'b0, 1'b1);
      checkFrame(8'h7E, 1'b0, 1'b0);

`ifdef UART_RX_OVR_EN
      sel = 0;
      clearFlags();
      applyStimulus(8'h11, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h22, 1'b0, 1'b0, 1'b1);
      checkOutput("ovr_data", data0, 8'h22);
      checkOutput("ovr_flag", ovr0, 1);
      fork
         applyStimulus(8'h33, 1'b0, 1'b0, 1'b1);
         begin
            @(posedge clk);
            repeat (model_latency(0)) @(posedge clk);
            #1 clr_rdy = 1'b1;
            @(posedge clk);
            #1 clr_rdy = 1'b0;
         end
      join
      checkOutput("clr_vs_set_rdy", rdy0, 1);
      checkOutput("clr_vs_set_data", data0, 8'h33);
      clearFlags();
      checkOutput("ovr_cleared", ovr0, 0);
`endif

      // Random frames against the reference model; rdy is sometimes left set.
      for (int i = 0; i < 24; i++) begin
         s   = int'($urandom_range(0, 2));
         d   = 8'($urandom);
         pb  = 1'($urandom_range(0, 1));
         st  = ($urandom_range(0, 5) != 0);
         sel = s;
         if ($urandom_range(0, 3) != 0) clearFlags();
         applyStimulus(d, pb, s != 0, st);
         checkFrame(d, !st, model_par_err(s, d, pb));
         repeat ($urandom_range(1, B)) @(posedge clk);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the serial command and telemetry links. It supports a configurable baud divisor, data width and parity mode. It detects false starts, framing errors and parity errors, and can optionally flag overruns. It sits between the asynchronous RX pin and the command/packet decoder. Every completed frame is presented on `rx_data` with a sticky `rdy` flag that the consumer clears.

## Interface
- `BAUD_DIV`, 5208: clocks per bit (50 MHz / 9600). Legal values ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `RX`  in  1  asynchronous serial input, idle high.
- `clr_rdy`  in  1  consumer acknowledge; clears `rdy` and all error flags.
- `rx_data`  out  DATA_BITS  last received data, LSB first on the line.
- `rdy`  out  1  frame available (sticky).
- `frm_err`  out  1  stop bit sampled low (sticky, valid when `rdy`=1).
- `par_err`  out  1  parity mismatch (sticky, valid when `rdy`=1); constant 0 when `PARITY`=0.
- `ovr_err`  out  1  overrun; present only with `UART_RX_OVR_EN`.

## Operation
- `RX` passes through a two-flop synchroniser; both flops reset to 1. All logic uses the synchronised value `rxs`.
- Baud counter:
  - Width `$clog2(BAUD_DIV)`, down-counting.
  - `HALF = BAUD_DIV>>1` (floor).
  - A sample pulse fires when the count is 0. The counter then reloads `BAUD_DIV-1`, so samples are exactly BAUD_DIV clocks apart.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE: on `rxs`=0, load counter with HALF and go to START.
- START: at the sample, `rxs`=1 is a false start; return to IDLE with no flag change. `rxs`=0 clears the bit counter and goes to DATA.
- DATA:
  - Each sample shifts `rxs` into the MSB of the DATA_BITS shift register (right shift).
  - After DATA_BITS samples, go to PAR if `PARITY`≠0, else STOP.
- PAR: sample the parity bit. Mismatch is computed as (XOR of data bits ^ parity bit) ≠ (`PARITY`==2 ? 1 : 0).
- STOP: at the sample:
  - Copy the shift register to `rx_data`.
  - `rdy` ← 1, `frm_err` ← ~`rxs`, `par_err` ← computed mismatch.
  - Return directly to IDLE, so a start edge immediately after the mid-stop sample is accepted.
- `rx_data` holds its value between frames and changes only at STOP completion.
- `clr_rdy` clears `rdy`, `frm_err`, `par_err` (and `ovr_err`). If it coincides with frame completion, the set wins.
- A new start bit does not clear `rdy`.

## Timing
- Reset values: `rx_data`=0, `rdy`=0, `frm_err`=0, `par_err`=0, `ovr_err`=0; FSM in IDLE; counter 0.
- Reset mid-frame aborts the frame immediately; no partial data is exposed.
- `rdy` rises HALF + (1 + DATA_BITS + P)·BAUD_DIV + 3 clocks (±1) after the `RX` falling edge, where P = (`PARITY`≠0).
- All outputs are registered. Flags update on the same edge as `rdy`.
- A glitch low shorter than HALF−2 clocks never produces `rdy`.
- A `RX` low held continuously (break) yields one frame with `rx_data`=0 and `frm_err`=1. The receiver then re-enters START only after `rxs` returns high and falls again.
  - To enforce this, IDLE requires that `rxs` has been seen high at least once since STOP.

## Configuration
- `UART_RX_OVR_EN` defined:
  - `ovr_err` port exists.
  - Frame completion while `rdy`=1 sets `ovr_err`=1, and `rx_data` is overwritten with the new frame.
  - `ovr_err` is cleared by `clr_rdy` or reset.
- Undefined: no `ovr_err` port or logic. Completion while `rdy`=1 silently overwrites `rx_data`.

## Test plan
All scenarios use `BAUD_DIV`=16, `DATA_BITS`=8 unless stated.
- `PARITY`=0, send 0xA5 with stop=1 -> `rx_data`=0xA5, `rdy`=1, `frm_err`=0, `par_err`=0 at the latency above. Then `clr_rdy` pulse -> `rdy`=0 next clock.
- Send 0x3C with stop bit 0 -> `rx_data`=0x3C, `rdy`=1, `frm_err`=1. Then `RX` back high, send 0x01 -> `rx_data`=0x01.
- `PARITY`=1 (even), send 0x03 with parity bit 1 -> `par_err`=1. Resend with parity 0 -> `par_err`=0. Repeat with `PARITY`=2 and the opposite expectations.
- `RX` low for 4 clocks, then high -> FSM back in IDLE, `rdy` stays 0. A following 0x55 frame is received correctly.
- With `UART_RX_OVR_EN`: send 0x11 then 0x22 without `clr_rdy` -> `rx_data`=0x22, `ovr_err`=1. Then `clr_rdy` asserted on the exact completion cycle of a third frame 0x33 -> `rdy`=1, `rx_data`=0x33.
- Assert `rst_n`=0 midway through the data bits -> all outputs 0 immediately. Release, send 0x7E -> `rx_data`=0x7E, no error flags.
